// File: rtl/ps2_tx_if.sv
// PS/2 host transmit request bundle.
// Master issues a byte; slave reports ready/done/error.
interface ps2_tx_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_error;

  modport master (
    output tx_valid,
    output tx_data,
    input  tx_ready,
    input  tx_done,
    input  tx_error
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    output tx_ready,
    output tx_done,
    output tx_error
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter.
// Open-drain outputs only; ACK checked, transfer guarded by a timeout.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 1500000
) (
  input  logic    clk,
  input  logic    rst_n,
  ps2_tx_if.slave tx,
  input  logic    ps2_clk_in,
  input  logic    ps2_data_in,
  output logic    ps2_clk_oe,
  output logic    ps2_data_oe
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    SHIFT,
    ACK,
    RECOVER
  } state_t;

  state_t        state;
  state_t        state_d;
  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          clk_prev;
  logic [IW-1:0] inh_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [3:0]    bit_cnt;
  logic [9:0]    sr;
  logic          done_q;
  logic          err_q;

  logic clk_s;
  logic data_s;
  logic fall;
  logic active;
  logic load;
  logic shift_en;
  logic done_d;
  logic err_d;

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];
  assign fall   = clk_prev & ~clk_s;
  assign active = state inside {START, SHIFT, ACK, RECOVER};

  assign tx.tx_done  = done_q;
  assign tx.tx_error = err_q;

  always_comb begin
    state_d     = state;
    load        = 1'b0;
    shift_en    = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    tx.tx_ready = 1'b0;
    unique case (state)
      IDLE: begin
        tx.tx_ready = 1'b1;
        if (tx.tx_valid) begin
          load    = 1'b1;
          state_d = INHIBIT;
        end
      end
      INHIBIT: begin
        ps2_clk_oe = 1'b1;
        // start bit goes out while clock is still held
        if (inh_cnt == INH_LAST) begin
          ps2_data_oe = 1'b1;
          state_d     = START;
        end
      end
      START: begin
        ps2_data_oe = 1'b1;
        if (fall) state_d = SHIFT;
      end
      SHIFT: begin
        ps2_data_oe = ~sr[0];
        if (fall) begin
          if (bit_cnt == 4'd9) state_d = ACK;
          else shift_en = 1'b1;
        end
      end
      ACK: begin
        if (data_s) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = RECOVER;
        end
      end
      RECOVER: begin
        if (clk_s && data_s) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // timeout overrides any completion in the same cycle
    if (active && tmo_cnt == TMO_LAST) begin
      state_d  = IDLE;
      shift_en = 1'b0;
      done_d   = 1'b0;
      err_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
      inh_cnt   <= '0;
      tmo_cnt   <= '0;
      bit_cnt   <= '0;
      sr        <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_d;
      clk_sync  <= {clk_sync[0], ps2_clk_in};
      data_sync <= {data_sync[0], ps2_data_in};
      clk_prev  <= clk_s;
      done_q    <= done_d;
      err_q     <= err_d;
      inh_cnt   <= (state == INHIBIT) ? inh_cnt + 1'b1 : '0;
      tmo_cnt   <= active ? tmo_cnt + 1'b1 : '0;
      if (load) begin
        sr      <= {1'b1, ~^tx.tx_data, tx.tx_data};
        bit_cnt <= '0;
      end else if (shift_en) begin
        sr      <= {1'b1, sr[9:1]};
        bit_cnt <= bit_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain device model.
// Timing parameters are scaled down to keep runs short.
module tb_ps2_host_tx;

  localparam int INH = 200;
  localparam int TMO = 3000;
  localparam int HP  = 25;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;
  logic ps2_clk_oe;
  logic ps2_data_oe;
  logic clk_line;
  logic data_line;

  int passed = 0;
  int total = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  ps2_tx_if bus ();

  assign clk_line  = ps2_clk_oe  ? 1'b0 : dev_clk;
  assign data_line = ps2_data_oe ? 1'b0 : dev_data;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx         (bus.slave),
    .ps2_clk_in (clk_line),
    .ps2_data_in(data_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.tx_done) done_cnt++;
    if (bus.tx_error) err_cnt++;
    if (bus.tx_done && bus.tx_error) both_cnt++;
  end

  task automatic accept(input logic [7:0] d);
    @(negedge clk);
    rst_n = 1'b1;
    bus.tx_valid = 1'b1;
    bus.tx_data = d;
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  task automatic measure_inhibit(output int hi, output int dhi);
    hi = 0;
    dhi = 0;
    while (ps2_clk_oe === 1'b1 && hi < INH + 100) begin
      hi++;
      if (ps2_data_oe === 1'b1) dhi++;
      @(negedge clk);
    end
  endtask

  task automatic dev_frame(
    input  bit          ack,
    input  int          stop_after,
    input  bit          inject,
    output logic [10:0] bits
  );
    bits = '0;
    repeat (HP) @(negedge clk);
    bits[0] = data_line;
    for (int k = 1; k <= 11; k++) begin
      dev_clk = 1'b0;
      repeat (HP) @(negedge clk);
      if (k <= 10) bits[k] = data_line;
      if (inject && k == 5) begin
        bus.tx_valid = 1'b1;
        bus.tx_data = 8'h00;
      end
      if (inject && k == 6) begin
        bus.tx_valid = 1'b0;
        bus.tx_data = 8'hF4;
      end
      dev_clk = 1'b1;
      if (k == stop_after) return;
      if (k == 10) dev_data = ack ? 1'b0 : 1'b1;
      repeat (HP) @(negedge clk);
      if (k == 11) dev_data = 1'b1;
    end
  endtask

  task automatic wait_ready(output bit ok);
    int n;
    n = 0;
    while (bus.tx_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    ok = (bus.tx_ready === 1'b1);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (bus.tx_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", bus.tx_ready);
    else passed++;
    total++;
    if (ps2_clk_oe !== 1'b0) $display("FAIL rst_clk_oe got %b want 0", ps2_clk_oe);
    else passed++;
    total++;
    if (ps2_data_oe !== 1'b0) $display("FAIL rst_data_oe got %b want 0", ps2_data_oe);
    else passed++;
    total++;
    if ({bus.tx_done, bus.tx_error} !== 2'b00)
      $display("FAIL rst_pulses got %b want 00", {bus.tx_done, bus.tx_error});
    else passed++;
  endtask

  task automatic test_f4_first_cycle;
    int hi, dhi, d0, e0;
    logic [10:0] bits;
    bit ok;
    d0 = done_cnt;
    e0 = err_cnt;
    accept(8'hF4);
    total++;
    if (bus.tx_ready !== 1'b0) $display("FAIL f4_ready_drop got %b want 0", bus.tx_ready);
    else passed++;
    measure_inhibit(hi, dhi);
    total++;
    if (hi !== INH) $display("FAIL f4_inhibit_len got %0d want %0d", hi, INH);
    else passed++;
    total++;
    if (dhi !== 1) $display("FAIL f4_start_in_inhibit got %0d want 1", dhi);
    else passed++;
    dev_frame(1'b1, 0, 1'b0, bits);
    total++;
    if (bits !== 11'h5E8) $display("FAIL f4_frame got %h want 5e8", bits);
    else passed++;
    wait_ready(ok);
    total++;
    if (ok !== 1'b1) $display("FAIL f4_ready_timeout got %b want 1", ok);
    else passed++;
    total++;
    if (done_cnt - d0 !== 1) $display("FAIL f4_done got %0d want 1", done_cnt - d0);
    else passed++;
    total++;
    if (err_cnt - e0 !== 0) $display("FAIL f4_err got %0d want 0", err_cnt - e0);
    else passed++;
  endtask

  task automatic test_ff;
    int hi, dhi, d0, e0;
    logic [10:0] bits;
    bit ok;
    d0 = done_cnt;
    e0 = err_cnt;
    accept(8'hFF);
    measure_inhibit(hi, dhi);
    dev_frame(1'b1, 0, 1'b0, bits);
    total++;
    if (bits !== 11'h7FE) $display("FAIL ff_frame got %h want 7fe", bits);
    else passed++;
    wait_ready(ok);
    total++;
    if (done_cnt - d0 !== 1) $display("FAIL ff_done got %0d want 1", done_cnt - d0);
    else passed++;
    total++;
    if (err_cnt - e0 !== 0) $display("FAIL ff_err got %0d want 0", err_cnt - e0);
    else passed++;
  endtask

  task automatic test_back_to_back;
    int hi, dhi, d0;
    logic [10:0] bits;
    bit ok;
    d0 = done_cnt;
    accept(8'h01);
    measure_inhibit(hi, dhi);
    total++;
    if (hi !== INH) $display("FAIL b2b_inhibit_len got %0d want %0d", hi, INH);
    else passed++;
    dev_frame(1'b1, 0, 1'b0, bits);
    total++;
    if (bits !== 11'h402) $display("FAIL b2b_frame got %h want 402", bits);
    else passed++;
    wait_ready(ok);
    total++;
    if (done_cnt - d0 !== 1) $display("FAIL b2b_done got %0d want 1", done_cnt - d0);
    else passed++;
  endtask

  task automatic test_nack;
    int hi, dhi, d0, e0;
    logic [10:0] bits;
    bit ok;
    d0 = done_cnt;
    e0 = err_cnt;
    accept(8'hF4);
    measure_inhibit(hi, dhi);
    dev_frame(1'b0, 0, 1'b0, bits);
    wait_ready(ok);
    total++;
    if (err_cnt - e0 !== 1) $display("FAIL nack_err got %0d want 1", err_cnt - e0);
    else passed++;
    total++;
    if (done_cnt - d0 !== 0) $display("FAIL nack_done got %0d want 0", done_cnt - d0);
    else passed++;
    total++;
    if ({ps2_clk_oe, ps2_data_oe, bus.tx_ready} !== 3'b001)
      $display("FAIL nack_idle got %b want 001", {ps2_clk_oe, ps2_data_oe, bus.tx_ready});
    else passed++;
  endtask

  task automatic test_timeout;
    int hi, dhi, n, d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    accept(8'hF4);
    measure_inhibit(hi, dhi);
    n = 0;
    while (bus.tx_error !== 1'b1 && n < TMO + 100) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n !== TMO) $display("FAIL tmo_latency got %0d want %0d", n, TMO);
    else passed++;
    total++;
    if ({ps2_clk_oe, ps2_data_oe} !== 2'b00)
      $display("FAIL tmo_release got %b want 00", {ps2_clk_oe, ps2_data_oe});
    else passed++;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (err_cnt - e0 !== 1) $display("FAIL tmo_err got %0d want 1", err_cnt - e0);
    else passed++;
    total++;
    if (done_cnt - d0 !== 0) $display("FAIL tmo_done got %0d want 0", done_cnt - d0);
    else passed++;
  endtask

  task automatic test_reset_mid;
    int hi, dhi, d0, e0;
    logic [10:0] bits;
    accept(8'hF4);
    measure_inhibit(hi, dhi);
    dev_frame(1'b1, 5, 1'b0, bits);
    d0 = done_cnt;
    e0 = err_cnt;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({ps2_clk_oe, ps2_data_oe, bus.tx_ready} !== 3'b001)
      $display("FAIL rmid_release got %b want 001", {ps2_clk_oe, ps2_data_oe, bus.tx_ready});
    else passed++;
    total++;
    if ({bus.tx_done, bus.tx_error} !== 2'b00)
      $display("FAIL rmid_pulse got %b want 00", {bus.tx_done, bus.tx_error});
    else passed++;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (done_cnt - d0 + err_cnt - e0 !== 0)
      $display("FAIL rmid_no_pulse got %0d want 0", done_cnt - d0 + err_cnt - e0);
    else passed++;
  endtask

  task automatic test_after_reset;
    int hi, dhi, d0;
    logic [10:0] bits;
    bit ok;
    d0 = done_cnt;
    accept(8'hF4);
    measure_inhibit(hi, dhi);
    dev_frame(1'b1, 0, 1'b0, bits);
    total++;
    if (bits !== 11'h5E8) $display("FAIL post_rst_frame got %h want 5e8", bits);
    else passed++;
    wait_ready(ok);
    total++;
    if (done_cnt - d0 !== 1) $display("FAIL post_rst_done got %0d want 1", done_cnt - d0);
    else passed++;
  endtask

  task automatic test_ignore_valid;
    int hi, dhi, d0;
    logic [10:0] bits;
    bit ok;
    d0 = done_cnt;
    accept(8'hF4);
    measure_inhibit(hi, dhi);
    dev_frame(1'b1, 0, 1'b1, bits);
    total++;
    if (bits !== 11'h5E8) $display("FAIL ign_frame got %h want 5e8", bits);
    else passed++;
    wait_ready(ok);
    repeat (5) @(negedge clk);
    total++;
    if (done_cnt - d0 !== 1) $display("FAIL ign_done got %0d want 1", done_cnt - d0);
    else passed++;
    total++;
    if (ps2_clk_oe !== 1'b0) $display("FAIL ign_no_restart got %b want 0", ps2_clk_oe);
    else passed++;
    total++;
    if (both_cnt !== 0) $display("FAIL both_pulses got %0d want 0", both_cnt);
    else passed++;
  endtask

  initial begin
    bus.tx_valid = 1'b0;
    bus.tx_data = 8'h00;
    test_reset();
    test_f4_first_cycle();
    test_ff();
    test_back_to_back();
    test_nack();
    test_timeout();
    test_reset_mid();
    test_after_reset();
    test_ignore_valid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
